sao_stat_accum: RTL and testbench

Per-CTU SAO statistics accumulator: the transmitting end of the stage-1 → stage-2 statistics hand-off. It accumulates clipped sample differences and hit counts per EO type/category and per BO band offset for one component of one CTU. At the end of the component it presents the totals and fires a one-cycle `able_to_pass` strobe, then holds them stable long enough for the stage-2 capture register (registered strobe, then copy) to latch them.

---
 rtl/sao_stat_accum.sv | 159 +++++++++++++++
 tb/tb_sao_stat_accum.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sao_stat_accum.sv
// Per-CTU SAO EO/BO statistics accumulator with stage-2 hand-off strobe.
// Optional: SAO_STAT_SAT_EN makes sums/counts saturate instead of wrap.
module sao_stat_accum #(
  parameter int diff_clip_bit    = 4,
  parameter int n_category       = 4,
  parameter int n_category_bo    = 8,
  parameter int num_pix_CTU_log2 = 5,
  parameter int num_accu_len     = num_pix_CTU_log2*2-1,
  parameter int n_eo_type        = 4
) (
  input  logic                       clk_slow,
  input  logic                       arst_n,
  input  logic                       rst_n,
  input  logic                       smp_vld,
  output logic                       smp_rdy,
  input  logic                       smp_last,
  input  logic [1:0]                 smp_cIdx,
  input  logic signed [diff_clip_bit:0] smp_diff,
  input  logic [3*n_eo_type-1:0]     eo_cat,
  input  logic                       bo_hit,
  input  logic [2:0]                 bo_idx,
  input  logic                       dc_busy,
  output logic                       able_to_pass,
  output logic                       end_of_luma_st,
  output logic                       end_of_chroma_st,
  output logic [1:0]                 cIdx_st,
  output logic signed [num_accu_len+diff_clip_bit:0]
    sum_blk_CTU [n_eo_type][n_category],
  output logic [num_accu_len:0]
    num_blk_CTU [n_eo_type][n_category],
  output logic signed [num_accu_len+diff_clip_bit:0]
    sum_blk_CTU_bo [n_category_bo],
  output logic [num_accu_len:0]
    num_blk_CTU_bo [n_category_bo]
);

  localparam int SW = num_accu_len + diff_clip_bit + 1;
  localparam int CW = num_accu_len + 1;
  localparam int SW1 = SW + 1;

  typedef enum logic [1:0] {
    S_ACC, S_WAIT, S_PASS, S_HOLD
  } state_t;

  state_t state, state_nx;
  logic   accept;
  logic   clr;

  function automatic logic signed [SW-1:0] add_sum(
    input logic signed [SW-1:0]            a,
    input logic signed [diff_clip_bit:0]   d
  );
`ifdef SAO_STAT_SAT_EN
    logic signed [SW:0] s;
    s = {a[SW-1], a} + SW1'(d);
    if (s[SW] != s[SW-1])
      return s[SW] ? {1'b1, {(SW-1){1'b0}}}
                   : {1'b0, {(SW-1){1'b1}}};
    return s[SW-1:0];
`else
    return a + SW'(d);
`endif
  endfunction

  function automatic logic [CW-1:0] add_cnt(
    input logic [CW-1:0] a
  );
`ifdef SAO_STAT_SAT_EN
    return (&a) ? a : a + CW'(1);
`else
    return a + CW'(1);
`endif
  endfunction

  assign smp_rdy = (state == S_ACC);
  assign accept  = smp_vld && smp_rdy;
  // Clear on the HOLD->ACC edge, after stage 2 has copied the totals
  assign clr     = !rst_n || (state == S_HOLD);

  always_ff @(posedge clk_slow or negedge arst_n) begin
    if (!arst_n)     state <= S_ACC;
    else if (!rst_n) state <= S_ACC;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    able_to_pass     = 1'b0;
    end_of_luma_st   = 1'b0;
    end_of_chroma_st = 1'b0;
    unique case (state)
      S_ACC:
        if (accept && smp_last)
          state_nx = dc_busy ? S_WAIT : S_PASS;
      S_WAIT:
        if (!dc_busy) state_nx = S_PASS;
      S_PASS: begin
        state_nx         = S_HOLD;
        able_to_pass     = 1'b1;
        end_of_luma_st   = (cIdx_st == 2'd0);
        end_of_chroma_st = (cIdx_st != 2'd0);
      end
      S_HOLD:
        state_nx = S_ACC;
      default:
        state_nx = S_ACC;
    endcase
  end

  always_ff @(posedge clk_slow or negedge arst_n) begin
    if (!arst_n)
      cIdx_st <= 2'd0;
    else if (!rst_n)
      cIdx_st <= 2'd0;
    else if (accept && smp_last)
      cIdx_st <= smp_cIdx;
  end

  always_ff @(posedge clk_slow or negedge arst_n) begin
    if (!arst_n) begin
      for (int t = 0; t < n_eo_type; t++)
        for (int c = 0; c < n_category; c++) begin
          sum_blk_CTU[t][c] <= '0;
          num_blk_CTU[t][c] <= '0;
        end
      for (int b = 0; b < n_category_bo; b++) begin
        sum_blk_CTU_bo[b] <= '0;
        num_blk_CTU_bo[b] <= '0;
      end
    end else if (clr) begin
      for (int t = 0; t < n_eo_type; t++)
        for (int c = 0; c < n_category; c++) begin
          sum_blk_CTU[t][c] <= '0;
          num_blk_CTU[t][c] <= '0;
        end
      for (int b = 0; b < n_category_bo; b++) begin
        sum_blk_CTU_bo[b] <= '0;
        num_blk_CTU_bo[b] <= '0;
      end
    end else if (accept) begin
      for (int t = 0; t < n_eo_type; t++)
        for (int c = 0; c < n_category; c++)
          if (eo_cat[3*t +: 3] == 3'(c + 1)) begin
            sum_blk_CTU[t][c] <=
              add_sum(sum_blk_CTU[t][c], smp_diff);
            num_blk_CTU[t][c] <=
              add_cnt(num_blk_CTU[t][c]);
          end
      for (int b = 0; b < n_category_bo; b++)
        if (bo_hit && bo_idx == 3'(b)) begin
          sum_blk_CTU_bo[b] <=
            add_sum(sum_blk_CTU_bo[b], smp_diff);
          num_blk_CTU_bo[b] <=
            add_cnt(num_blk_CTU_bo[b]);
        end
    end
  end

endmodule

// File: tb/tb_sao_stat_accum.sv
// Directed self-checking bench for sao_stat_accum.
// Build with SAO_STAT_SAT_EN to check the saturating variant.
module tb_sao_stat_accum;

  logic clk_slow = 1'b0;
  logic arst_n, rst_n;
  logic smp_vld, smp_rdy, smp_last;
  logic [1:0] smp_cIdx;
  logic signed [4:0] smp_diff;
  logic [11:0] eo_cat;
  logic bo_hit;
  logic [2:0] bo_idx;
  logic dc_busy;
  logic able_to_pass;
  logic end_of_luma_st, end_of_chroma_st;
  logic [1:0] cIdx_st;
  logic signed [13:0] sum_blk_CTU [4][4];
  logic [9:0] num_blk_CTU [4][4];
  logic signed [13:0] sum_blk_CTU_bo [8];
  logic [9:0] num_blk_CTU_bo [8];

  int checks = 0;
  int errors = 0;

  always #5 clk_slow = ~clk_slow;

  sao_stat_accum dut (
    .clk_slow         (clk_slow),
    .arst_n           (arst_n),
    .rst_n            (rst_n),
    .smp_vld          (smp_vld),
    .smp_rdy          (smp_rdy),
    .smp_last         (smp_last),
    .smp_cIdx         (smp_cIdx),
    .smp_diff         (smp_diff),
    .eo_cat           (eo_cat),
    .bo_hit           (bo_hit),
    .bo_idx           (bo_idx),
    .dc_busy          (dc_busy),
    .able_to_pass     (able_to_pass),
    .end_of_luma_st   (end_of_luma_st),
    .end_of_chroma_st (end_of_chroma_st),
    .cIdx_st          (cIdx_st),
    .sum_blk_CTU      (sum_blk_CTU),
    .num_blk_CTU      (num_blk_CTU),
    .sum_blk_CTU_bo   (sum_blk_CTU_bo),
    .num_blk_CTU_bo   (num_blk_CTU_bo)
  );

  task automatic chk(
    input string tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d",
        tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic send(
    input int d, input logic [11:0] cat,
    input logic bh, input logic [2:0] bi,
    input logic last, input logic [1:0] ci
  );
    smp_vld  = 1'b1;
    smp_diff = 5'(d);
    eo_cat   = cat;
    bo_hit   = bh;
    bo_idx   = bi;
    smp_last = last;
    smp_cIdx = ci;
    @(posedge clk_slow);
    @(negedge clk_slow);
    smp_vld  = 1'b0;
    smp_last = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk_slow);
    @(negedge clk_slow);
  endtask

  localparam logic [11:0] CAT_A =
    {3'd4, 3'd0, 3'd2, 3'd1};
  localparam logic [11:0] CAT_T0 = 12'd1;

  initial begin
    arst_n = 1'b0; rst_n = 1'b1;
    smp_vld = 0; smp_last = 0; smp_cIdx = 0;
    smp_diff = 0; eo_cat = 0; bo_hit = 0;
    bo_idx = 0; dc_busy = 0;
    #12;
    chk("rst_rdy", smp_rdy, 1'b1);
    chk("rst_atp", able_to_pass, 1'b0);
    chk("rst_sum", sum_blk_CTU[0][0], 0);
    chk("rst_cidx", cIdx_st, 2'd0);
    @(negedge clk_slow);
    arst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++)
      send(3, CAT_T0, 1'b1, 3'd2, 1'b0, 2'd0);
    chk("acc10_sum", sum_blk_CTU[0][0], 30);
    chk("acc10_bo", num_blk_CTU_bo[2], 10'd10);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_sum", sum_blk_CTU[0][0], 0);
    chk("arst_bo", num_blk_CTU_bo[2], 10'd0);
    chk("arst_rdy", smp_rdy, 1'b1);
    chk("arst_atp", able_to_pass, 1'b0);
    @(negedge clk_slow);
    arst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++)
      send(3, CAT_A, 1'b1, 3'd5, i == 3, 2'd0);
    chk("l_atp", able_to_pass, 1'b1);
    chk("l_luma", end_of_luma_st, 1'b1);
    chk("l_chroma", end_of_chroma_st, 1'b0);
    chk("l_s00", sum_blk_CTU[0][0], 12);
    chk("l_s11", sum_blk_CTU[1][1], 12);
    chk("l_s33", sum_blk_CTU[3][3], 12);
    chk("l_sbo5", sum_blk_CTU_bo[5], 12);
    chk("l_n00", num_blk_CTU[0][0], 10'd4);
    chk("l_n11", num_blk_CTU[1][1], 10'd4);
    chk("l_n33", num_blk_CTU[3][3], 10'd4);
    chk("l_nbo5", num_blk_CTU_bo[5], 10'd4);
    chk("l_n20", num_blk_CTU[2][0], 10'd0);
    chk("l_s10", sum_blk_CTU[1][0], 0);
    chk("l_rdy", smp_rdy, 1'b0);
    tick();
    chk("h_atp", able_to_pass, 1'b0);
    chk("h_rdy", smp_rdy, 1'b0);
    chk("h_s00", sum_blk_CTU[0][0], 12);
    chk("h_nbo5", num_blk_CTU_bo[5], 10'd4);
    tick();
    chk("c_s00", sum_blk_CTU[0][0], 0);
    chk("c_nbo5", num_blk_CTU_bo[5], 10'd0);
    chk("c_rdy", smp_rdy, 1'b1);

    for (int i = 0; i < 4; i++)
      send(3, CAT_A, 1'b1, 3'd5, i == 3, 2'd2);
    chk("ch_atp", able_to_pass, 1'b1);
    chk("ch_chroma", end_of_chroma_st, 1'b1);
    chk("ch_luma", end_of_luma_st, 1'b0);
    chk("ch_cidx", cIdx_st, 2'd2);
    chk("ch_s33", sum_blk_CTU[3][3], 12);
    tick();
    tick();

    send(-2, 12'o0030, 1'b1, 3'd0, 1'b0, 2'd1);
    dc_busy = 1'b1;
    send(-2, 12'o0030, 1'b1, 3'd0, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++) begin
      chk("w_rdy", smp_rdy, 1'b0);
      chk("w_atp", able_to_pass, 1'b0);
      smp_vld = 1'b1; smp_diff = 5'sd7;
      eo_cat = 12'o0030;
      tick();
    end
    dc_busy = 1'b0;
    chk("w_atp_end", able_to_pass, 1'b0);
    chk("w_s12", sum_blk_CTU[1][2], -4);
    tick();
    smp_vld = 1'b0;
    chk("wp_atp", able_to_pass, 1'b1);
    chk("wp_chroma", end_of_chroma_st, 1'b1);
    chk("wp_s12", sum_blk_CTU[1][2], -4);
    chk("wp_n12", num_blk_CTU[1][2], 10'd2);
    chk("wp_sbo0", sum_blk_CTU_bo[0], -4);
    tick();
    tick();
    chk("wc_rdy", smp_rdy, 1'b1);
    chk("wc_s12", sum_blk_CTU[1][2], 0);

    send(5, 12'o0100, 1'b0, 3'd0, 1'b1, 2'd0);
    chk("rp_atp", able_to_pass, 1'b1);
    chk("rp_s20", sum_blk_CTU[2][0], 5);
    rst_n = 1'b0;
    tick();
    chk("rr_atp", able_to_pass, 1'b0);
    chk("rr_s20", sum_blk_CTU[2][0], 0);
    chk("rr_rdy", smp_rdy, 1'b1);
    rst_n = 1'b1;
    tick();
    chk("rr2_atp", able_to_pass, 1'b0);
    chk("rr2_rdy", smp_rdy, 1'b1);

    for (int i = 0; i < 600; i++)
      send(-8, CAT_T0, 1'b0, 3'd0, 1'b0, 2'd0);
    chk("b600_sum", sum_blk_CTU[0][0], -4800);
    chk("b600_num", num_blk_CTU[0][0], 10'd600);
    for (int i = 0; i < 500; i++)
      send(-8, CAT_T0, 1'b0, 3'd0, 1'b0, 2'd0);
`ifdef SAO_STAT_SAT_EN
    chk("b1100_sum", sum_blk_CTU[0][0], -8192);
    chk("b1100_num", num_blk_CTU[0][0], 10'd1023);
`else
    chk("b1100_sum", sum_blk_CTU[0][0], 7584);
    chk("b1100_num", num_blk_CTU[0][0], 10'd76);
`endif
    chk("b1100_rdy", smp_rdy, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
